// File: rtl/fft_frame_tx.sv
// Snapshots a completed FFT frame and streams it as A5 5A, per-bin payload, XOR checksum.
// Payload is |re|+|im| per bin; define FFT_TX_RAW_EN to send raw re/im components instead.
module fft_frame_tx #(
   parameter int unsigned N = 64,
   parameter int unsigned W = 18
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           dataReady,
   input  logic [N*W-1:0] Yreal,
   input  logic [N*W-1:0] Yimag,
   output logic [7:0]     tx_data,
   output logic           tx_valid,
   input  logic           tx_ready,
   output logic           busy,
   output logic           overrun
);

`ifdef FFT_TX_RAW_EN
   localparam int unsigned Bpb = 6;
`else
   localparam int unsigned Bpb = 3;
`endif
   localparam int unsigned ByteW = (Bpb > 4) ? 3 : 2;
   localparam int unsigned BinW  = (N > 1) ? $clog2(N) : 1;
   localparam logic [BinW-1:0]  LastBin  = BinW'(N - 1);
   localparam logic [ByteW-1:0] LastByte = ByteW'(Bpb - 1);

   typedef enum logic [2:0] {StIdle, StSync0, StSync1, StBin, StCsum} state_e;

   state_e           state_q, state_d;
   logic             dr_q;
   logic [N*W-1:0]   re_q, im_q;
   logic [BinW-1:0]  bin_q, bin_d;
   logic [ByteW-1:0] byte_q, byte_d;
   logic [7:0]       csum_q, csum_d;
   logic             overrun_q;
   logic             evt, xfer, capture, csum_xfer;
   logic [W-1:0]     re_cur, im_cur;
   logic [23:0]      word;
   logic [1:0]       pos;
   logic [7:0]       bin_byte;

   assign evt    = dataReady & ~dr_q;
   assign re_cur = re_q[bin_q*W +: W];
   assign im_cur = im_q[bin_q*W +: W];

`ifdef FFT_TX_RAW_EN
   // Bytes 0..2 carry re, bytes 3..5 carry im, each sign-extended to 24 bits.
   always_comb begin
      if (byte_q < ByteW'(3)) begin
         word = {{(24-W){re_cur[W-1]}}, re_cur};
         pos  = byte_q[1:0];
      end else begin
         word = {{(24-W){im_cur[W-1]}}, im_cur};
         pos  = 2'(byte_q - ByteW'(3));
      end
   end
`else
   logic [W-1:0] abs_re, abs_im;
   logic [W:0]   mag;

   // Unsigned W-bit result keeps |-2^(W-1)| exact.
   assign abs_re = re_cur[W-1] ? (~re_cur + W'(1)) : re_cur;
   assign abs_im = im_cur[W-1] ? (~im_cur + W'(1)) : im_cur;
   assign mag    = {1'b0, abs_re} + {1'b0, abs_im};
   assign word   = {{(23-W){1'b0}}, mag};
   assign pos    = byte_q;
`endif

   always_comb begin
      case (pos)
         2'd0:    bin_byte = word[23:16];
         2'd1:    bin_byte = word[15:8];
         default: bin_byte = word[7:0];
      endcase
   end

   always_comb begin
      tx_data = 8'h00;
      unique case (state_q)
         StSync0: tx_data = 8'hA5;
         StSync1: tx_data = 8'h5A;
         StBin:   tx_data = bin_byte;
         StCsum:  tx_data = csum_q;
         default: tx_data = 8'h00;
      endcase
   end

   assign tx_valid  = (state_q != StIdle);
   assign busy      = (state_q != StIdle);
   assign xfer      = tx_valid & tx_ready;
   assign csum_xfer = (state_q == StCsum) & xfer;
   assign overrun   = overrun_q;

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      byte_d  = byte_q;
      csum_d  = csum_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (evt) begin
               capture = 1'b1;
               state_d = StSync0;
            end
         end
         StSync0: if (xfer) state_d = StSync1;
         StSync1: if (xfer) state_d = StBin;
         StBin: begin
            if (xfer) begin
               csum_d = csum_q ^ tx_data;
               if (byte_q == LastByte) begin
                  byte_d = '0;
                  if (bin_q == LastBin) begin
                     bin_d   = '0;
                     state_d = StCsum;
                  end else begin
                     bin_d = bin_q + 1'b1;
                  end
               end else begin
                  byte_d = byte_q + 1'b1;
               end
            end
         end
         StCsum: begin
            if (xfer) begin
               if (evt) begin
                  capture = 1'b1;
                  state_d = StSync0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (capture) begin
         bin_d  = '0;
         byte_d = '0;
         csum_d = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         dr_q      <= 1'b0;
         re_q      <= '0;
         im_q      <= '0;
         bin_q     <= '0;
         byte_q    <= '0;
         csum_q    <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dr_q    <= dataReady;
         bin_q   <= bin_d;
         byte_q  <= byte_d;
         csum_q  <= csum_d;
         if (capture) begin
            re_q <= Yreal;
            im_q <= Yimag;
         end
         // Only a CSUM transfer can take a new frame while busy; anything else is dropped.
         if (evt && busy && !csum_xfer) overrun_q <= 1'b1;
      end
   end

endmodule

// File: doc/fft_frame_tx.md
Name: fft_frame_tx

Overview:
- Downstream consumer of the 64-point FFT block.
- On each FFT completion it snapshots the packed Yreal/Yimag buses and reduces each bin to a magnitude.
- It streams the frame as a framed byte sequence over a valid/ready interface into the UART transmitter.
- The FFT is free to start its next frame while the previous one drains.

Parameters:
- N, 64, number of FFT bins per frame
- W, 18, signed two's-complement width of each real/imag component

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- dataReady  input  1  FFT result valid (level or pulse; rising edge is the event)
- Yreal  input  N*W  packed real parts, bin i at [W*i +: W]
- Yimag  input  N*W  packed imaginary parts, same packing
- tx_data  output  8  byte to UART
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART accepts byte
- busy  output  1  frame in progress (any state but IDLE)
- overrun  output  1  sticky: a frame was dropped

Behaviour:
- Reset (rst=0, async): state=IDLE, tx_valid=0, tx_data=0, busy=0, overrun=0, edge register=0, shadow regs=0, bin/byte counters=0, checksum=0. Reset mid-frame aborts the frame; tx_valid drops immediately.
- Edge detect: dr_q registered each cycle; event = dataReady & ~dr_q. A constant-high dataReady yields one event.
- Capture: when an event is accepted, both buses are copied into shadow regs on that edge.
  - Next cycle: state=SYNC0, tx_valid=1, tx_data=0xA5.
  - Latency from the dataReady rising edge to the first tx_valid is 1 cycle.
- Transfer rule: a byte transfers on a rising edge with tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid never deasserts without a transfer, except on reset.
- FSM:
  - IDLE -> SYNC0 on event.
  - SYNC0 (0xA5) -> SYNC1 (0x5A) on transfer.
  - SYNC1 -> BIN on transfer.
  - BIN: for bin k = 0..N-1, send bytes b2, b1, b0 of a 24-bit word, MSB first. Advance byte, then bin, on each transfer. After byte b0 of bin N-1 -> CSUM.
  - CSUM: tx_data = XOR of all BIN-state bytes; sync bytes are excluded. On transfer -> IDLE, or directly -> SYNC0 if an event occurs in that same cycle (capture performed).
- Magnitude: mag = |re| + |im|.
  - |x| is computed as a W-bit unsigned value; |-2^(W-1)| = 2^(W-1) exactly.
  - Sum is W+1 bits (max 2^W), zero-extended to 24 bits.
  - Computed from the shadow regs of the current bin; no rounding, no saturation needed.
- Frame length (default): 2 + 3*N + 1 = 195 bytes.
- Overrun: an event while busy, other than in the CSUM-transfer cycle, is ignored. The shadow regs and the current stream are unaffected and overrun is set to 1. Only reset clears overrun.
- Checksum register clears on capture and XOR-accumulates each BIN byte as it transfers.

Optional Feature:
- Macro FFT_TX_RAW_EN.
- Defined: BIN sends raw components instead of magnitude: per bin, re then im, each sign-extended to 24 bits, MSB first (6 bytes/bin). Frame is 2 + 6*N + 1 = 387 bytes. The checksum covers all 6*N bytes.
- Undefined: magnitude mode as above. No raw datapath is synthesized.

Test Plan:
- All-zero Yreal/Yimag, dataReady pulse, tx_ready=1 -> A5 5A, then 192 x 00, then checksum 00. busy high for exactly 195 cycles.
- Bin0 re=1 im=-1, bin5 re=im=-131072, others 0 -> bin0 bytes 00 00 02; bin5 bytes 04 00 00; checksum 06.
- tx_ready=0 for 10 cycles while byte 3 (bin0 b2) is presented -> tx_data and tx_valid held constant for all 10 cycles; stream resumes with no byte lost or repeated.
- Second dataReady rising edge during bin 20 -> overrun=1; the current frame completes with the original data and unchanged checksum. dataReady held high continuously produces only one frame.
- Event coinciding with the CSUM transfer -> the next cycle shows tx_valid=1 with tx_data=A5, carrying the new data. overrun stays 0.
- rst asserted low mid-BIN -> tx_valid, busy, and overrun all 0 immediately. After release, a new event yields a clean 195-byte frame.
- FFT_TX_RAW_EN defined, bin0 re=-1 im=2 -> FF FF FF 00 00 02; total 387 bytes.
